multi_port_register_file: RTL

//  Architectural register file plus rename/dependency table for a DISPATCH_W-wide dispatcher and COMMIT_W-wide RoB commit.

---
 rtl/rf_pkg.sv | 26 ++
 rtl/rf_operand_lookup.sv | 70 +++++++
 rtl/multi_port_register_file.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared widths, sentinel encodings and lookup result type for the register file.
// No logic of its own; constants and one helper used by the top and the lookup lanes.
// No flow control: pure type/constant package.
package rf_pkg;

  localparam int REG_WIDTH    = 5;
  localparam int REG_SIZE     = 1 << REG_WIDTH;
  localparam int EX_REG_WIDTH = 6;
  localparam int RoB_WIDTH    = 8;
  localparam int EX_RoB_WIDTH = RoB_WIDTH + 1;

  // "No register" and "no dependency" are the first out-of-range encodings.
  localparam logic [EX_REG_WIDTH-1:0] NON_REG = EX_REG_WIDTH'(REG_SIZE);
  localparam logic [EX_RoB_WIDTH-1:0] NON_DEP = EX_RoB_WIDTH'(1 << RoB_WIDTH);

  typedef struct packed {
    logic [EX_RoB_WIDTH-1:0] tag;
    logic [31:0]             value;
  } lookup_t;

  // True when the index names a writable architectural register (not x0, not NON_REG).
  function automatic logic is_arch_reg(input logic [EX_REG_WIDTH-1:0] r);
    return (r != NON_REG) && (r != '0);
  endfunction

endpackage

// File: rtl/rf_operand_lookup.sv
// Resolves one source operand to a RoB tag or a ready value for one dispatch lane.
// Latency: purely combinational.
// Backpressure: none; the caller gates state updates with the global enable.
module rf_operand_lookup
  import rf_pkg::*;
#(
  parameter int OLDER    = 0,
  parameter int COMMIT_W = 2,
  parameter int OW       = (OLDER > 0) ? OLDER : 1
) (
  input  logic                         flush,
  input  logic [EX_REG_WIDTH-1:0]      src,
  input  logic [OW-1:0]                older_en,
  input  logic [OW*EX_REG_WIDTH-1:0]   older_rd,
  input  logic [OW*RoB_WIDTH-1:0]      older_tag,
  input  logic [COMMIT_W-1:0]          commit_en,
  input  logic [COMMIT_W*RoB_WIDTH-1:0] commit_idx,
  input  logic [COMMIT_W*EX_REG_WIDTH-1:0] commit_rd,
  input  logic [COMMIT_W*32-1:0]       commit_value,
  input  logic [EX_RoB_WIDTH-1:0]      dep_data,
  input  logic [31:0]                  reg_data,
  output lookup_t                      result
);

  logic                 fwd_hit;
  logic [RoB_WIDTH-1:0] fwd_tag;
  logic                 cm_hit;
  logic [31:0]          cm_val;

  // Priority resolution: flush, no-reg/x0, older-lane rename, commit bypass, file, pending tag.
  always_comb begin
    fwd_hit      = 1'b0;
    fwd_tag      = '0;
    cm_hit       = 1'b0;
    cm_val       = '0;
    result.tag   = NON_DEP;
    result.value = '0;

    // Later (younger) older-lanes overwrite earlier hits so the youngest producer wins.
    for (int i = 0; i < OW; i++) begin
      if ((i < OLDER) && older_en[i] && (older_rd[i*EX_REG_WIDTH +: EX_REG_WIDTH] == src)) begin
        fwd_hit = 1'b1;
        fwd_tag = older_tag[i*RoB_WIDTH +: RoB_WIDTH];
      end
    end

    // RoB indices are unique, so at most one commit lane can match the pending tag.
    for (int c = 0; c < COMMIT_W; c++) begin
      if (commit_en[c] && (commit_rd[c*EX_REG_WIDTH +: EX_REG_WIDTH] == src) &&
          (dep_data == {1'b0, commit_idx[c*RoB_WIDTH +: RoB_WIDTH]})) begin
        cm_hit = 1'b1;
        cm_val = commit_value[c*32 +: 32];
      end
    end

    if (flush || !is_arch_reg(src)) begin
      result.tag   = NON_DEP;
      result.value = '0;
    end else if (fwd_hit) begin
      result.tag = {1'b0, fwd_tag};
    end else if (cm_hit) begin
      result.value = cm_val;
    end else if (dep_data == NON_DEP) begin
      result.value = reg_data;
    end else begin
      result.tag = dep_data;
    end
  end

endmodule

// File: rtl/multi_port_register_file.sv
// Architectural register file plus rename table for a multi-lane dispatcher and RoB commit.
// Latency: operand lookup combinational; state updates next edge; debug read 1 cycle.
// Backpressure: Sys_rdy=0 freezes registers and dependencies; the debug port keeps running.
module multi_port_register_file
  import rf_pkg::*;
#(
  parameter int DISPATCH_W = 2,
  parameter int COMMIT_W   = 2
) (
  input  logic                             Sys_clk,
  input  logic                             Sys_rst,
  input  logic                             Sys_rdy,
  input  logic [DISPATCH_W-1:0]            DPRF_en,
  input  logic [DISPATCH_W*EX_REG_WIDTH-1:0] DPRF_rs1,
  input  logic [DISPATCH_W*EX_REG_WIDTH-1:0] DPRF_rs2,
  input  logic [DISPATCH_W*EX_REG_WIDTH-1:0] DPRF_rd,
  input  logic [DISPATCH_W*RoB_WIDTH-1:0]  DPRF_RoB_index,
  output logic [DISPATCH_W*EX_RoB_WIDTH-1:0] RFDP_Qj,
  output logic [DISPATCH_W*EX_RoB_WIDTH-1:0] RFDP_Qk,
  output logic [DISPATCH_W*32-1:0]         RFDP_Vj,
  output logic [DISPATCH_W*32-1:0]         RFDP_Vk,
  input  logic                             RoBRF_flush,
  input  logic [COMMIT_W-1:0]              RoBRF_en,
  input  logic [COMMIT_W*RoB_WIDTH-1:0]    RoBRF_RoB_index,
  input  logic [COMMIT_W*EX_REG_WIDTH-1:0] RoBRF_rd,
  input  logic [COMMIT_W*32-1:0]           RoBRF_value,
  input  logic                             DBG_rd_en,
  input  logic [REG_WIDTH-1:0]             DBG_rd_addr,
  output logic                             DBG_rd_valid,
  output logic [31:0]                      DBG_rd_data
);

  logic [31:0]             registers  [REG_SIZE];
  logic [EX_RoB_WIDTH-1:0] dependency [REG_SIZE];

  for (genvar d = 0; d < DISPATCH_W; d++) begin : g_lane
    localparam int OW = (d > 0) ? d : 1;
    logic [EX_REG_WIDTH-1:0]    rs1, rs2;
    logic [OW-1:0]              o_en;
    logic [OW*EX_REG_WIDTH-1:0] o_rd;
    logic [OW*RoB_WIDTH-1:0]    o_tag;
    lookup_t                    res_j, res_k;

    assign rs1 = DPRF_rs1[d*EX_REG_WIDTH +: EX_REG_WIDTH];
    assign rs2 = DPRF_rs2[d*EX_REG_WIDTH +: EX_REG_WIDTH];

    if (d > 0) begin : g_older
      assign o_en  = DPRF_en[d-1:0];
      assign o_rd  = DPRF_rd[d*EX_REG_WIDTH-1:0];
      assign o_tag = DPRF_RoB_index[d*RoB_WIDTH-1:0];
    end else begin : g_oldest
      assign o_en  = '0;
      assign o_rd  = '0;
      assign o_tag = '0;
    end

    rf_operand_lookup #(.OLDER(d), .COMMIT_W(COMMIT_W), .OW(OW)) u_j (
      .flush       (RoBRF_flush),
      .src         (rs1),
      .older_en    (o_en),
      .older_rd    (o_rd),
      .older_tag   (o_tag),
      .commit_en   (RoBRF_en),
      .commit_idx  (RoBRF_RoB_index),
      .commit_rd   (RoBRF_rd),
      .commit_value(RoBRF_value),
      .dep_data    (dependency[rs1[REG_WIDTH-1:0]]),
      .reg_data    (registers[rs1[REG_WIDTH-1:0]]),
      .result      (res_j)
    );

    rf_operand_lookup #(.OLDER(d), .COMMIT_W(COMMIT_W), .OW(OW)) u_k (
      .flush       (RoBRF_flush),
      .src         (rs2),
      .older_en    (o_en),
      .older_rd    (o_rd),
      .older_tag   (o_tag),
      .commit_en   (RoBRF_en),
      .commit_idx  (RoBRF_RoB_index),
      .commit_rd   (RoBRF_rd),
      .commit_value(RoBRF_value),
      .dep_data    (dependency[rs2[REG_WIDTH-1:0]]),
      .reg_data    (registers[rs2[REG_WIDTH-1:0]]),
      .result      (res_k)
    );

    assign RFDP_Qj[d*EX_RoB_WIDTH +: EX_RoB_WIDTH] = res_j.tag;
    assign RFDP_Vj[d*32 +: 32]                     = res_j.value;
    assign RFDP_Qk[d*EX_RoB_WIDTH +: EX_RoB_WIDTH] = res_k.tag;
    assign RFDP_Vk[d*32 +: 32]                     = res_k.value;
  end

  // Architectural state update: commits write values, then clears, then dispatch renames.
  // Statement order sets priority: higher lanes override lower, and a dispatch to the
  // same rd overrides a commit clear, which is exactly "clear only if no dispatch targets rd".
  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      for (int r = 0; r < REG_SIZE; r++) begin
        registers[r]  <= '0;
        dependency[r] <= NON_DEP;
      end
    end else if (Sys_rdy) begin
      for (int c = 0; c < COMMIT_W; c++) begin
        if (RoBRF_en[c] && is_arch_reg(RoBRF_rd[c*EX_REG_WIDTH +: EX_REG_WIDTH])) begin
          registers[RoBRF_rd[c*EX_REG_WIDTH +: REG_WIDTH]] <= RoBRF_value[c*32 +: 32];
        end
      end
      if (RoBRF_flush) begin
        for (int r = 0; r < REG_SIZE; r++) begin
          dependency[r] <= NON_DEP;
        end
      end else begin
        for (int c = 0; c < COMMIT_W; c++) begin
          if (RoBRF_en[c] && is_arch_reg(RoBRF_rd[c*EX_REG_WIDTH +: EX_REG_WIDTH]) &&
              (dependency[RoBRF_rd[c*EX_REG_WIDTH +: REG_WIDTH]] ==
               {1'b0, RoBRF_RoB_index[c*RoB_WIDTH +: RoB_WIDTH]})) begin
            dependency[RoBRF_rd[c*EX_REG_WIDTH +: REG_WIDTH]] <= NON_DEP;
          end
        end
        for (int d = 0; d < DISPATCH_W; d++) begin
          if (DPRF_en[d] && is_arch_reg(DPRF_rd[d*EX_REG_WIDTH +: EX_REG_WIDTH])) begin
            dependency[DPRF_rd[d*EX_REG_WIDTH +: REG_WIDTH]] <=
              {1'b0, DPRF_RoB_index[d*RoB_WIDTH +: RoB_WIDTH]};
          end
        end
      end
    end
  end

  // Debug read: samples the file before this edge's commits land; ignores Sys_rdy.
  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      DBG_rd_valid <= 1'b0;
      DBG_rd_data  <= '0;
    end else begin
      DBG_rd_valid <= DBG_rd_en;
      if (DBG_rd_en) begin
        DBG_rd_data <= registers[DBG_rd_addr];
      end
    end
  end

endmodule
